mips_regfile_addr_unit: RTL and testbench
=========================================

Name: mips_regfile_addr_unit

Overview:
- Decode-stage datapath block of the multicycle MIPS core.
- Contains the 32x32 general-purpose register file with a registered two-port read and a one-port write.
- Also contains two combinational address helpers:
  - Jump-target concatenation.
  - Branch-offset word shift of the sign-extended immediate.
- Sits between the instruction register / sign extender and the A/B operand registers, ALU muxes and PC-source mux.

Parameters:
- DW, 32, data word width (helpers assume 32).
- AW, 5, register address width.
- NREG, 32, number of registers (2**AW).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- dir_a  in  AW  read address port A (rs)
- dir_b  in  AW  read address port B (rt)
- dir_wra  in  AW  write address (rt/rd from dest mux)
- di  in  DW  write data (from data-select mux)
- reg_rd  in  1  read enable; latches doa/dob
- reg_wr  in  1  write enable
- doa  out  DW  registered read data A
- dob  out  DW  registered read data B
- pc  in  32  current PC
- output_jump  in  28  jump field already shifted left 2
- output_concat  out  32  jump target
- immediate  in  32  sign-extended immediate
- output_imm  out  32  branch offset

Behaviour:
- Reset (reset=0, async):
  - All NREG registers clear to 0.
  - doa and dob clear to 0.
  - Reset takes priority over any pending write or read at the same edge.
  - Reset asserted mid-operation discards the in-flight write.
- Write: on posedge clk with reset=1 and reg_wr=1, rf[dir_wra] <= di.
  - Writes to address 0 are ignored; rf[0] always reads 0.
- Read: on posedge clk with reset=1 and reg_rd=1, doa <= rf[dir_a] and dob <= rf[dir_b].
  - One-cycle latency: data is valid the cycle after reg_rd is sampled.
  - With reg_rd=0, doa and dob hold their last value.
- Read and write in the same cycle to the same nonzero address: read returns the pre-write (old) value (default build).
- dir_a == dir_b is legal; both outputs get the same value.
- No handshake; reg_rd and reg_wr are level-sampled single-cycle strobes from the controller.
- output_concat = {pc[31:28], output_jump[27:0]}. Purely combinational.
- output_imm = {immediate[29:0], 2'b00}. Purely combinational.
  - Sign is preserved for in-range offsets; bits 31:30 of the input are discarded.
  - Examples: 0xFFFFFFFF -> 0xFFFFFFFC; 0x00000001 -> 0x00000004.
- The combinational outputs are unaffected by reset and clk.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: a same-edge read and write to the same nonzero address (reg_rd=1, reg_wr=1, dir_a or dir_b == dir_wra != 0) loads di into the matching doa/dob, i.e. write-first forwarding.
  - Address 0 is never forwarded; it still reads 0.
- Undefined: read-old-value behaviour as above.

Decomposition:
- Shared package mips_dp_pkg holds:
  - DW and AW constants.
  - REG_ZERO = 5'd0.
  - PC_HI_BITS = 4 (top PC bits kept on jump).
  - IMM_SHIFT = 2.
- One sub-module is natural: mips_regfile, which holds the storage array, write logic and registered read ports.
- Concatenation and immediate shift stay as continuous assignments in the top.

Test Plan:
- Reset clears state: assert reset=0 with reg_rd=1 on every address pair -> doa=dob=0; after release, reading all 32 addresses -> all 0.
- Write then read:
  - Write 0xDEADBEEF to r5 and 0x12345678 to r31.
  - Next cycle, dir_a=5, dir_b=31, reg_rd=1 -> one edge later doa=0xDEADBEEF, dob=0x12345678.
  - Drop reg_rd, change addresses -> outputs hold.
- r0 protection: write 0xFFFFFFFF to r0, then read dir_a=0 -> doa=0.
- Same-cycle read/write of r7 (old value 0x1, di=0x2):
  - Default build -> doa=0x1.
  - With RF_BYPASS_EN -> doa=0x2.
  - Following read -> 0x2 in both builds.
- Jump concatenation: pc=0xA0001234, output_jump=0x0ABCDEF -> output_concat=0xA0ABCDEF.
- Immediate shift:
  - 0x00000001 -> 0x00000004.
  - 0xFFFFFFFE -> 0xFFFFFFF8.
  - 0x00003FFF -> 0x0000FFFC.
- Async reset mid-write: pulse reset low between edges while reg_wr=1 -> target register reads 0 afterwards.

Source files
------------

// File: rtl/mips_dp_pkg.sv
// Shared decode-stage datapath constants and types.
// Consumed by mips_regfile and mips_regfile_addr_unit.
package mips_dp_pkg;

  localparam int DW         = 32;
  localparam int AW         = 5;
  localparam int NREG       = 32;
  localparam int PC_HI_BITS = 4;
  localparam int IMM_SHIFT  = 2;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] raddr_t;

  typedef struct packed {
    logic   rd;
    logic   wr;
    raddr_t a;
    raddr_t b;
    raddr_t wra;
    word_t  di;
  } rf_req_t;

  function automatic logic wr_live(input rf_req_t r);
    return r.wr && (r.wra != REG_ZERO);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: async-clear storage, one write port, two registered reads.
// RF_BYPASS_EN selects write-first forwarding on same-edge read/write hits.
module mips_regfile
  import mips_dp_pkg::*;
#(
  parameter int DW   = mips_dp_pkg::DW,
  parameter int AW   = mips_dp_pkg::AW,
  parameter int NREG = mips_dp_pkg::NREG
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  rf_req_t       req_i,
  output logic [DW-1:0] doa_o,
  output logic [DW-1:0] dob_o
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] doa_q, dob_q;
  logic [DW-1:0] doa_d, dob_d;
  logic          we;

  assign we = wr_live(req_i);

`ifdef RF_BYPASS_EN
  logic fwd_a, fwd_b;

  // r0 never forwards because we already excludes it
  assign fwd_a = we && (req_i.a == req_i.wra);
  assign fwd_b = we && (req_i.b == req_i.wra);

  always_comb begin
    doa_d = fwd_a ? req_i.di : rf_q[req_i.a];
    dob_d = fwd_b ? req_i.di : rf_q[req_i.b];
  end
`else
  always_comb begin
    doa_d = rf_q[req_i.a];
    dob_d = rf_q[req_i.b];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      doa_q <= '0;
      dob_q <= '0;
    end else begin
      if (we) begin
        rf_q[req_i.wra] <= req_i.di;
      end
      if (req_i.rd) begin
        doa_q <= doa_d;
        dob_q <= dob_d;
      end
    end
  end

  assign doa_o = doa_q;
  assign dob_o = dob_q;

endmodule

// File: rtl/mips_regfile_addr_unit.sv
// Decode-stage block: register file plus jump-target and branch-offset helpers.
// Optional macro RF_BYPASS_EN enables write-first read forwarding.
module mips_regfile_addr_unit
  import mips_dp_pkg::*;
#(
  parameter int DW   = mips_dp_pkg::DW,
  parameter int AW   = mips_dp_pkg::AW,
  parameter int NREG = mips_dp_pkg::NREG
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] dir_a,
  input  logic [AW-1:0] dir_b,
  input  logic [AW-1:0] dir_wra,
  input  logic [DW-1:0] di,
  input  logic          reg_rd,
  input  logic          reg_wr,
  output logic [DW-1:0] doa,
  output logic [DW-1:0] dob,
  input  logic [31:0]   pc,
  input  logic [27:0]   output_jump,
  output logic [31:0]   output_concat,
  input  logic [31:0]   immediate,
  output logic [31:0]   output_imm
);

  rf_req_t req;

  always_comb begin
    req     = '0;
    req.rd  = reg_rd;
    req.wr  = reg_wr;
    req.a   = dir_a;
    req.b   = dir_b;
    req.wra = dir_wra;
    req.di  = di;
  end

  mips_regfile #(
    .DW   (DW),
    .AW   (AW),
    .NREG (NREG)
  ) u_rf (
    .clk_i  (clk),
    .rst_ni (reset),
    .req_i  (req),
    .doa_o  (doa),
    .dob_o  (dob)
  );

  // Jump keeps the PC region; branch offset drops the top two immediate bits
  assign output_concat = {pc[31 -: PC_HI_BITS], output_jump};
  assign output_imm    = {immediate[31-IMM_SHIFT:0], {IMM_SHIFT{1'b0}}};

endmodule

// File: tb/tb_mips_regfile_addr_unit.sv
// Self-checking bench for mips_regfile_addr_unit: array model plus literal checks.
// Build with +define+RF_BYPASS_EN to check the forwarding variant.
module tb_mips_regfile_addr_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  dir_a = '0, dir_b = '0, dir_wra = '0;
  logic [31:0] di = '0;
  logic        reg_rd = 1'b0, reg_wr = 1'b0;
  logic [31:0] doa, dob;
  logic [31:0] pc = '0;
  logic [27:0] output_jump = '0;
  logic [31:0] output_concat;
  logic [31:0] immediate = '0;
  logic [31:0] output_imm;

  int n_cmp = 0;
  int n_err = 0;

  mips_regfile_addr_unit dut (
    .clk           (clk),
    .reset         (reset),
    .dir_a         (dir_a),
    .dir_b         (dir_b),
    .dir_wra       (dir_wra),
    .di            (di),
    .reg_rd        (reg_rd),
    .reg_wr        (reg_wr),
    .doa           (doa),
    .dob           (dob),
    .pc            (pc),
    .output_jump   (output_jump),
    .output_concat (output_concat),
    .immediate     (immediate),
    .output_imm    (output_imm)
  );

  always #5 clk = ~clk;

  // Reference model: plain array, reads sampled before the write lands
  logic [31:0] m_rf [32];
  logic [31:0] m_doa = '0, m_dob = '0;

  always @(posedge clk or negedge reset) begin : model
    logic [31:0] ra, rb;
    if (!reset) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
      m_doa <= '0;
      m_dob <= '0;
    end else begin
      ra = (dir_a == 0) ? 32'd0 : m_rf[dir_a];
      rb = (dir_b == 0) ? 32'd0 : m_rf[dir_b];
`ifdef RF_BYPASS_EN
      if (reg_wr && dir_wra != 0 && dir_a == dir_wra) ra = di;
      if (reg_wr && dir_wra != 0 && dir_b == dir_wra) rb = di;
`endif
      if (reg_rd) begin
        m_doa <= ra;
        m_dob <= rb;
      end
      if (reg_wr && dir_wra != 0) m_rf[dir_wra] <= di;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, registered and combinational outputs
  always @(negedge clk) begin
    chk("model_doa", doa, m_doa);
    chk("model_dob", dob, m_dob);
    chk("model_concat", output_concat,
        (pc & 32'hF000_0000) | {4'h0, output_jump});
    chk("model_imm", output_imm, immediate * 32'd4);
  end

  // Inputs change at negedge+1 so the compare process never races them
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wr = 1'b1; dir_wra = a; di = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    reg_rd = 1'b1; dir_a = a; dir_b = b;
    tick();
    reg_rd = 1'b0;
  endtask

  initial begin
    // Reset held with reads on every address pair
    @(negedge clk); #1;
    reg_rd = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dir_a = 5'(i); dir_b = 5'(31 - i);
      tick();
    end
    chk("rst_doa", doa, 32'h0);
    chk("rst_dob", dob, 32'h0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      dir_a = 5'(i); dir_b = 5'(i);
      tick();
      if (i == 17) chk("post_rst_r17", doa, 32'h0);
    end
    reg_rd = 1'b0;

    // Write then read, then hold
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    rd(5'd5, 5'd31);
    chk("rd_r5", doa, 32'hDEAD_BEEF);
    chk("rd_r31", dob, 32'h1234_5678);
    dir_a = 5'd3; dir_b = 5'd4;
    tick(); tick();
    chk("hold_a", doa, 32'hDEAD_BEEF);
    chk("hold_b", dob, 32'h1234_5678);

    // r0 protection
    wr(5'd0, 32'hFFFF_FFFF);
    rd(5'd0, 5'd5);
    chk("r0_zero", doa, 32'h0);

    // Same-edge read/write of r7
    wr(5'd7, 32'h1);
    reg_wr = 1'b1; dir_wra = 5'd7; di = 32'h2;
    reg_rd = 1'b1; dir_a = 5'd7; dir_b = 5'd7;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
`ifdef RF_BYPASS_EN
    chk("rw_same_a", doa, 32'h2);
    chk("rw_same_b", dob, 32'h2);
`else
    chk("rw_same_a", doa, 32'h1);
    chk("rw_same_b", dob, 32'h1);
`endif
    rd(5'd7, 5'd0);
    chk("rw_after", doa, 32'h2);
    chk("rw_after_r0", dob, 32'h0);

    // Combinational helpers
    pc = 32'hA000_1234; output_jump = 28'h0AB_CDEF;
    #1 chk("concat", output_concat, 32'hA0AB_CDEF);
    immediate = 32'h0000_0001;
    #1 chk("imm_1", output_imm, 32'h0000_0004);
    immediate = 32'hFFFF_FFFE;
    #1 chk("imm_neg2", output_imm, 32'hFFFF_FFF8);
    immediate = 32'h0000_3FFF;
    #1 chk("imm_3fff", output_imm, 32'h0000_FFFC);
    immediate = 32'hFFFF_FFFF;
    #1 chk("imm_neg1", output_imm, 32'hFFFF_FFFC);
    @(negedge clk); #1;

    // Randomized traffic, addresses biased to collide
    for (int n = 0; n < 400; n++) begin
      reg_wr      = ($urandom_range(0, 2) != 0);
      reg_rd      = ($urandom_range(0, 2) != 0);
      dir_a       = 5'($urandom_range(0, 7));
      dir_b       = (n % 5 == 0) ? dir_a : 5'($urandom_range(0, 31));
      dir_wra     = (n % 3 == 0) ? dir_a : 5'($urandom_range(0, 7));
      di          = $urandom;
      pc          = $urandom;
      output_jump = 28'($urandom);
      immediate   = $urandom;
      tick();
    end
    reg_wr = 1'b0; reg_rd = 1'b0;

    // Async reset straddling a write edge
    wr(5'd9, 32'hCAFE_F00D);
    rd(5'd9, 5'd9);
    chk("r9_set", doa, 32'hCAFE_F00D);
    reg_wr = 1'b1; dir_wra = 5'd9; di = 32'h5555_AAAA;
    #2 reset = 1'b0;
    #4 reset = 1'b1;
    @(negedge clk); #1;
    reg_wr = 1'b0;
    chk("async_doa", doa, 32'h0);
    rd(5'd9, 5'd5);
    chk("async_r9", doa, 32'h0);
    chk("async_r5", dob, 32'h0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
